// File: rtl/sipo_deser_ctrl.sv
// Sequencer for an external SIPO shift register: accepts a val/rdy serial bit
// stream (MSB first), steers the register, and offers each finished word on a val/rdy port.
module sipo_deser_ctrl #(
  parameter int BITWIDTH = 32,
  parameter int CNT_W    = $clog2(BITWIDTH + 1)
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                SER_VAL,
  input  logic                SER_BIT,
  output logic                SER_RDY,
  input  logic                ABORT,
  output logic                SR_LOAD_EN,
  output logic                SR_SHIFT_EN,
  output logic                SR_IN,
  output logic [BITWIDTH-1:0] SR_LOAD_DATA,
  input  logic [BITWIDTH-1:0] SR_OUT,
  output logic [BITWIDTH-1:0] RECV_MSG,
  output logic                RECV_VAL,
  input  logic                RECV_RDY,
  output logic [CNT_W-1:0]    BIT_CNT,
  output logic                BUSY
);

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BITWIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ser_rdy;
  logic             recv_val;
  logic             ser_fire;
  logic             recv_fire;

  // Handshake side: readiness and word-valid depend only on state, RECV_RDY and ABORT.
  always_comb begin
    ser_rdy  = 1'b0;
    recv_val = 1'b0;
    case (state)
      CLEAR: begin
        ser_rdy  = 1'b0;
        recv_val = 1'b0;
      end
      IDLE: begin
        ser_rdy  = 1'b1;
      end
      SHIFT: begin
        ser_rdy  = 1'b1;
      end
      HOLD: begin
        // A new bit may only enter on the edge that hands off the held word.
        recv_val = 1'b1;
        ser_rdy  = RECV_RDY;
      end
      default: begin
        ser_rdy  = 1'b0;
        recv_val = 1'b0;
      end
    endcase
    if (ABORT) begin
      ser_rdy  = 1'b0;
      recv_val = 1'b0;
    end
  end

  assign ser_fire  = SER_VAL & ser_rdy;
  assign recv_fire = recv_val & RECV_RDY;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (ABORT) begin
      state_nxt = CLEAR;
      cnt_nxt   = '0;
    end else begin
      case (state)
        CLEAR: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
        IDLE: begin
          if (ser_fire) begin
            state_nxt = SHIFT;
            cnt_nxt   = CNT_ONE;
          end
        end
        SHIFT: begin
          if (ser_fire) begin
            if (cnt == CNT_LAST) begin
              state_nxt = HOLD;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt   = cnt + CNT_ONE;
            end
          end
        end
        HOLD: begin
          if (recv_fire) begin
            if (ser_fire) begin
              state_nxt = SHIFT;
              cnt_nxt   = CNT_ONE;
            end else begin
              state_nxt = IDLE;
              cnt_nxt   = '0;
            end
          end
        end
        default: begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Register drive: load only in CLEAR (where ser_rdy is 0), so load and shift never overlap.
  assign SR_LOAD_EN   = (state == CLEAR);
  assign SR_SHIFT_EN  = ser_fire;
  assign SR_IN        = SER_BIT;
  assign SR_LOAD_DATA = '0;

  assign SER_RDY  = ser_rdy;
  assign RECV_VAL = recv_val;
  assign RECV_MSG = SR_OUT;
  assign BIT_CNT  = cnt;
  assign BUSY     = (state == SHIFT) || (state == HOLD);

endmodule

// File: tb/tb_sipo_deser_ctrl.sv
// Directed bench for sipo_deser_ctrl (BITWIDTH=8) with a behavioural SIPO register attached.
module tb_sipo_deser_ctrl;

  localparam int BW = 8;
  localparam int CW = $clog2(BW + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          ser_val, ser_bit, ser_rdy, abort;
  logic          sr_load_en, sr_shift_en, sr_in;
  logic [BW-1:0] sr_load_data, sr_out, recv_msg;
  logic          recv_val, recv_rdy, busy;
  logic [CW-1:0] bit_cnt;

  always #5 clk = ~clk;

  sipo_deser_ctrl #(.BITWIDTH(BW)) dut (
    .CLK(clk), .RESET(rst), .SER_VAL(ser_val), .SER_BIT(ser_bit), .SER_RDY(ser_rdy),
    .ABORT(abort), .SR_LOAD_EN(sr_load_en), .SR_SHIFT_EN(sr_shift_en), .SR_IN(sr_in),
    .SR_LOAD_DATA(sr_load_data), .SR_OUT(sr_out), .RECV_MSG(recv_msg), .RECV_VAL(recv_val),
    .RECV_RDY(recv_rdy), .BIT_CNT(bit_cnt), .BUSY(busy)
  );

  // External shift register: load wins, otherwise shift left with IN entering the LSB.
  always @(posedge clk) begin
    if (sr_load_en) sr_out <= sr_load_data;
    else if (sr_shift_en) sr_out <= {sr_out[BW-2:0], sr_in};
  end

  typedef struct packed {
    logic       val;
    logic       bit_v;
    logic       abt;
    logic       rdy;
    logic       e_srdy;
    logic       e_rval;
    logic       e_shift;
    logic       e_load;
    logic       e_busy;
    logic [3:0] e_cnt;
    logic       chk_msg;
    logic [7:0] e_msg;
  } vec_t;

  vec_t vq[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic add(input logic v, input logic b, input logic a, input logic r,
                     input logic srdy, input logic rval, input logic sh, input logic ld,
                     input logic bz, input logic [3:0] c, input logic cm, input logic [7:0] m);
    vec_t x;
    x = '{v, b, a, r, srdy, rval, sh, ld, bz, c, cm, m};
    vq.push_back(x);
  endtask

  // Eight accepted bits starting from IDLE, MSB first.
  task automatic add_word(input logic [7:0] w, input logic r);
    for (int i = 0; i < 8; i++)
      add(1'b1, w[7-i], 1'b0, r, 1'b1, 1'b0, 1'b1, 1'b0, (i != 0), 4'(i), 1'b0, 8'h00);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] ctl_now();
    return {ser_rdy, recv_val, sr_shift_en, sr_load_en, busy, 4'(bit_cnt)};
  endfunction

  initial begin
    logic [7:0] w5a;
    logic [4:0] part;
    rst = 1'b1; ser_val = 0; ser_bit = 0; abort = 0; recv_rdy = 0;

    // Reset release, then 8'hA5 with consumer ready
    add(0,0,0,0, 0,0,0,1,0, 4'd0, 0, 8'h00);
    add_word(8'hA5, 1'b1);
    add(0,0,0,1, 1,1,0,0,1, 4'd0, 1, 8'hA5);
    add(0,0,0,1, 1,0,0,0,0, 4'd0, 1, 8'hA5);
    // Backpressure on 8'h3C, then zero-bubble restart
    add_word(8'h3C, 1'b0);
    for (int i = 0; i < 5; i++) add(1,1,0,0, 0,1,0,0,1, 4'd0, 1, 8'h3C);
    add(1,1,0,1, 1,1,1,0,1, 4'd0, 1, 8'h3C);
    add(0,0,0,1, 1,0,0,0,1, 4'd1, 0, 8'h00);
    // Gapped input completes 8'hFF
    for (int k = 1; k <= 7; k++) begin
      add(1,1,0,1, 1,0,1,0,1, 4'(k), 0, 8'h00);
      if (k < 7) add(0,0,0,1, 1,0,0,0,1, 4'(k+1), 0, 8'h00);
    end
    add(0,0,0,1, 1,1,0,0,1, 4'd0, 1, 8'hFF);
    add(0,0,0,1, 1,0,0,0,0, 4'd0, 0, 8'h00);
    // Abort after three bits
    add(1,1,0,1, 1,0,1,0,0, 4'd0, 0, 8'h00);
    add(1,0,0,1, 1,0,1,0,1, 4'd1, 0, 8'h00);
    add(1,1,0,1, 1,0,1,0,1, 4'd2, 0, 8'h00);
    add(1,1,1,1, 0,0,0,0,1, 4'd3, 0, 8'h00);
    add(1,1,0,1, 0,0,0,1,0, 4'd0, 0, 8'h00);
    add(0,0,0,1, 1,0,0,0,0, 4'd0, 1, 8'h00);
    // Abort while holding 8'h81, then abort again in CLEAR
    add_word(8'h81, 1'b0);
    add(0,0,0,0, 0,1,0,0,1, 4'd0, 1, 8'h81);
    add(1,1,1,1, 0,0,0,0,1, 4'd0, 1, 8'h81);
    add(1,0,1,1, 0,0,0,1,0, 4'd0, 0, 8'h00);
    add(1,0,0,1, 0,0,0,1,0, 4'd0, 0, 8'h00);
    add(0,0,0,1, 1,0,0,0,0, 4'd0, 1, 8'h00);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("in_reset", 32'(ctl_now()), 32'({5'b00010, 4'd0}));
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      ser_val = vq[i].val; ser_bit = vq[i].bit_v; abort = vq[i].abt; recv_rdy = vq[i].rdy;
      #1;
      check($sformatf("vec%0d_ctl", i), 32'(ctl_now()),
            32'({vq[i].e_srdy, vq[i].e_rval, vq[i].e_shift, vq[i].e_load, vq[i].e_busy, vq[i].e_cnt}));
      if (vq[i].chk_msg) check($sformatf("vec%0d_msg", i), 32'(recv_msg), 32'(vq[i].e_msg));
      @(negedge clk);
    end

    // Async reset with BIT_CNT=5, no clock edge between assert and check
    ser_val = 0; abort = 0; recv_rdy = 1;
    part = 5'b10110;
    for (int i = 0; i < 5; i++) begin
      ser_val = 1; ser_bit = part[4-i];
      @(negedge clk);
    end
    ser_val = 1; ser_bit = 1;
    #1 check("pre_reset_cnt", 32'(bit_cnt), 32'd5);
    #2 rst = 1'b1;
    #1 check("async_reset", 32'(ctl_now()), 32'({5'b00010, 4'd0}));
    @(negedge clk);
    ser_val = 0;
    rst = 1'b0;
    #1 check("post_reset_clear", 32'(ctl_now()), 32'({5'b00010, 4'd0}));
    @(negedge clk);
    #1 check("post_reset_idle", 32'(ctl_now()), 32'({5'b10000, 4'd0}));
    check("post_reset_msg", 32'(recv_msg), 32'h00);
    @(negedge clk);
    w5a = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      ser_val = 1; ser_bit = w5a[7-i];
      @(negedge clk);
    end
    ser_val = 0;
    begin
      int t;
      t = 0;
      #1;
      while (!recv_val && t < 4) begin
        @(negedge clk); #1; t++;
      end
      check("recovery_val", 32'(recv_val), 32'd1);
      check("recovery_msg", 32'(recv_msg), 32'h5A);
      check("recovery_latency", 32'(t), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
